// File: rtl/hazard_pipe_tracker.sv
// hazard_pipe_tracker: fetch PC, F->D instruction register and the D->E->M->W
// address/write-control pipeline consumed by the hazard unit, plus
// retire/bubble performance counters. Every output comes straight from a flop.
module hazard_pipe_tracker #(
    parameter int AW      = 8,
    parameter int XLEN    = 32,
    parameter int PC_STEP = 4,
    parameter int CW      = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] InstrF,
    input  logic [AW-1:0]   RA1D,
    input  logic [AW-1:0]   RA2D,
    input  logic [AW-1:0]   WA3D,
    input  logic            RegWriteD,
    input  logic            MemtoRegD,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            FlushE,
    input  logic            BranchTakenE,
    input  logic [XLEN-1:0] BranchTargetE,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] InstrD,
    output logic            ValidD,
    output logic [AW-1:0]   RA1E,
    output logic [AW-1:0]   RA2E,
    output logic [AW-1:0]   WA3E,
    output logic            RegWriteE,
    output logic            MemtoRegE,
    output logic [AW-1:0]   WA3M,
    output logic            RegWriteM,
    output logic            MemtoRegM,
    output logic [AW-1:0]   WA3W,
    output logic            RegWriteW,
    output logic            MemtoRegW,
    output logic [CW-1:0]   RetireCount,
    output logic [CW-1:0]   BubbleCount
);

    // Number of edges after reset before W reflects a slot that was really
    // launched from D; bubbles seen before that are pipe-fill, not stalls.
    localparam logic [2:0] FILL_EDGES = 3'd4;

    // Valid bits mark a stage slot that holds a real instruction; a zero valid
    // bit is a bubble and always carries RegWrite=0 and MemtoReg=0.
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] instrd_q, instrd_d;
    logic            validd_q, validd_d;
    logic [AW-1:0]   ra1e_q, ra1e_d, ra2e_q, ra2e_d, wa3e_q, wa3e_d;
    logic            regwritee_q, regwritee_d, memtorege_q, memtorege_d;
    logic            valide_q, valide_d;
    logic [AW-1:0]   wa3m_q, wa3w_q;
    logic            regwritem_q, memtoregm_q, validm_q;
    logic            regwritew_q, memtoregw_q, validw_q;
    logic [CW-1:0]   retire_q, retire_d, bubble_q, bubble_d;
    logic [2:0]      fill_q, fill_d;

    // Fetch PC: a taken branch beats StallF, otherwise step with natural wrap.
    always_comb begin
        pcf_d = pcf_q;
        if (BranchTakenE) begin
            pcf_d = BranchTargetE;
        end else if (!StallF) begin
            pcf_d = pcf_q + XLEN'(PC_STEP);
        end
    end

    // D register: flush beats stall; otherwise capture the fetched instruction.
    always_comb begin
        instrd_d = instrd_q;
        validd_d = validd_q;
        if (FlushD) begin
            instrd_d = '0;
            validd_d = 1'b0;
        end else if (!StallD) begin
            instrd_d = InstrF;
            validd_d = 1'b1;
        end
    end

    // E register: capture D fields gated by ValidD, or insert a bubble on FlushE.
    always_comb begin
        ra1e_d      = RA1D;
        ra2e_d      = RA2D;
        wa3e_d      = WA3D;
        regwritee_d = RegWriteD & validd_q;
        memtorege_d = MemtoRegD & validd_q;
        valide_d    = validd_q;
        if (FlushE) begin
            ra1e_d      = '0;
            ra2e_d      = '0;
            wa3e_d      = '0;
            regwritee_d = 1'b0;
            memtorege_d = 1'b0;
            valide_d    = 1'b0;
        end
    end

    // Counters: retire on a valid W slot, count bubbles only once the pipe has filled.
    always_comb begin
        retire_d = retire_q;
        bubble_d = bubble_q;
        fill_d   = fill_q;
        if (validw_q) begin
            retire_d = retire_q + CW'(1);
        end else if (fill_q == FILL_EDGES) begin
            bubble_d = bubble_q + CW'(1);
        end
        if (fill_q != FILL_EDGES) begin
            fill_d = fill_q + 3'd1;
        end
    end

    // State registers; M and W advance unconditionally from the stage before.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcf_q       <= '0;
            instrd_q    <= '0;
            validd_q    <= 1'b0;
            ra1e_q      <= '0;
            ra2e_q      <= '0;
            wa3e_q      <= '0;
            regwritee_q <= 1'b0;
            memtorege_q <= 1'b0;
            valide_q    <= 1'b0;
            wa3m_q      <= '0;
            regwritem_q <= 1'b0;
            memtoregm_q <= 1'b0;
            validm_q    <= 1'b0;
            wa3w_q      <= '0;
            regwritew_q <= 1'b0;
            memtoregw_q <= 1'b0;
            validw_q    <= 1'b0;
            retire_q    <= '0;
            bubble_q    <= '0;
            fill_q      <= '0;
        end else begin
            pcf_q       <= pcf_d;
            instrd_q    <= instrd_d;
            validd_q    <= validd_d;
            ra1e_q      <= ra1e_d;
            ra2e_q      <= ra2e_d;
            wa3e_q      <= wa3e_d;
            regwritee_q <= regwritee_d;
            memtorege_q <= memtorege_d;
            valide_q    <= valide_d;
            wa3m_q      <= wa3e_q;
            regwritem_q <= regwritee_q;
            memtoregm_q <= memtorege_q;
            validm_q    <= valide_q;
            wa3w_q      <= wa3m_q;
            regwritew_q <= regwritem_q;
            memtoregw_q <= memtoregm_q;
            validw_q    <= validm_q;
            retire_q    <= retire_d;
            bubble_q    <= bubble_d;
            fill_q      <= fill_d;
        end
    end

    assign PCF         = pcf_q;
    assign InstrD      = instrd_q;
    assign ValidD      = validd_q;
    assign RA1E        = ra1e_q;
    assign RA2E        = ra2e_q;
    assign WA3E        = wa3e_q;
    assign RegWriteE   = regwritee_q;
    assign MemtoRegE   = memtorege_q;
    assign WA3M        = wa3m_q;
    assign RegWriteM   = regwritem_q;
    assign MemtoRegM   = memtoregm_q;
    assign WA3W        = wa3w_q;
    assign RegWriteW   = regwritew_q;
    assign MemtoRegW   = memtoregw_q;
    assign RetireCount = retire_q;
    assign BubbleCount = bubble_q;

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
// Bench for hazard_pipe_tracker: directed scenarios followed by random
// stall/flush/branch traffic, checked cycle by cycle against a slot-history model.
module tb_hazard_pipe_tracker;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic [31:0] InstrF, BranchTargetE;
    logic [7:0]  RA1D, RA2D, WA3D;
    logic        RegWriteD, MemtoRegD, StallF, StallD, FlushD, FlushE, BranchTakenE;
    logic [31:0] PCF, InstrD;
    logic        ValidD;
    logic [7:0]  RA1E, RA2E, WA3E, WA3M, WA3W;
    logic        RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW, MemtoRegW;
    logic [31:0] RetireCount, BubbleCount;

    hazard_pipe_tracker #(.AW(8), .XLEN(32), .PC_STEP(4), .CW(32)) dut (
        .clk(clk), .reset(reset), .InstrF(InstrF),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
        .PCF(PCF), .InstrD(InstrD), .ValidD(ValidD),
        .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .WA3M(WA3M), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .WA3W(WA3W), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .RetireCount(RetireCount), .BubbleCount(BubbleCount)
    );

    // ---------------- reference model ----------------
    // A slot launched into E is remembered in a history list; the list position
    // is its age, so age 0 is E, age 1 is M, age 2 is W.
    typedef struct packed {
        logic [7:0] ra1, ra2, wa3;
        logic       rw, m2r, v;
    } ent_t;

    typedef struct packed {
        logic [31:0] pcf, instrd;
        logic        vd;
        logic [7:0]  ra1e, ra2e, wa3e;
        logic        rwe, m2re;
        logic [7:0]  wa3m;
        logic        rwm, m2rm;
        logic [7:0]  wa3w;
        logic        rww, m2rw;
        logic [31:0] ret, bub;
    } exp_t;

    localparam int EW = $bits(exp_t);

    ent_t        hist[$];
    logic [31:0] m_pc, m_instr, m_ret, m_bub;
    logic        m_vd;
    int          m_edges;

    function automatic void model_reset();
        m_pc = 0; m_instr = 0; m_vd = 0; m_ret = 0; m_bub = 0; m_edges = 0;
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back('0);
    endfunction

    function automatic void model_edge();
        ent_t e;
        if (!reset) begin
            model_reset();
            return;
        end
        if (hist[2].v) m_ret = m_ret + 1;
        else if (m_edges >= 4) m_bub = m_bub + 1;
        if (m_edges < 4) m_edges = m_edges + 1;
        if (FlushE) e = '0;
        else e = '{ra1: RA1D, ra2: RA2D, wa3: WA3D,
                   rw: RegWriteD && m_vd, m2r: MemtoRegD && m_vd, v: m_vd};
        hist.push_front(e);
        void'(hist.pop_back());
        if (FlushD) begin
            m_instr = 0; m_vd = 0;
        end else if (!StallD) begin
            m_instr = InstrF; m_vd = 1;
        end
        if (BranchTakenE) m_pc = BranchTargetE;
        else if (!StallF) m_pc = m_pc + 32'd4;
    endfunction

    function automatic exp_t snapshot();
        exp_t s;
        s.pcf = m_pc; s.instrd = m_instr; s.vd = m_vd;
        s.ra1e = hist[0].ra1; s.ra2e = hist[0].ra2; s.wa3e = hist[0].wa3;
        s.rwe = hist[0].rw; s.m2re = hist[0].m2r;
        s.wa3m = hist[1].wa3; s.rwm = hist[1].rw; s.m2rm = hist[1].m2r;
        s.wa3w = hist[2].wa3; s.rww = hist[2].rw; s.m2rw = hist[2].m2r;
        s.ret = m_ret; s.bub = m_bub;
        return s;
    endfunction

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    endtask

    // Monitor: every cycle the DUT presents a full output set; check it on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            while (exp_q.size() > 0) begin
                e = exp_t'(exp_q.pop_front());
                chk("sb_pcf", PCF, e.pcf);
                chk("sb_instrd", InstrD, e.instrd);
                chk("sb_validd", ValidD, e.vd);
                chk("sb_ra1e", RA1E, e.ra1e);
                chk("sb_ra2e", RA2E, e.ra2e);
                chk("sb_wa3e", WA3E, e.wa3e);
                chk("sb_rwe", RegWriteE, e.rwe);
                chk("sb_m2re", MemtoRegE, e.m2re);
                chk("sb_wa3m", WA3M, e.wa3m);
                chk("sb_rwm", RegWriteM, e.rwm);
                chk("sb_m2rm", MemtoRegM, e.m2rm);
                chk("sb_wa3w", WA3W, e.wa3w);
                chk("sb_rww", RegWriteW, e.rww);
                chk("sb_m2rw", MemtoRegW, e.m2rw);
                chk("sb_retire", RetireCount, e.ret);
                chk("sb_bubble", BubbleCount, e.bub);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        exp_q.push_back(EW'(snapshot()));
        #1;
    endtask

    task automatic clear_inputs();
        RA1D = 0; RA2D = 0; WA3D = 0; RegWriteD = 0; MemtoRegD = 0;
        StallF = 0; StallD = 0; FlushD = 0; FlushE = 0;
        BranchTakenE = 0; BranchTargetE = 0;
    endtask

    task automatic randomize_inputs();
        InstrF = $urandom();
        RA1D = 8'($urandom_range(0, 255));
        RA2D = 8'($urandom_range(0, 255));
        WA3D = 8'($urandom_range(0, 255));
        RegWriteD = 1'($urandom_range(0, 1));
        MemtoRegD = 1'($urandom_range(0, 1));
        StallF = ($urandom_range(0, 7) == 0);
        StallD = ($urandom_range(0, 7) == 0);
        FlushD = ($urandom_range(0, 7) == 0);
        FlushE = ($urandom_range(0, 5) == 0);
        BranchTakenE = ($urandom_range(0, 15) == 0);
        BranchTargetE = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        InstrF = 32'hDEAD_BEEF;
        clear_inputs();
        model_reset();

        // Reset held for three edges.
        repeat (3) step();
        chk("rst_pcf", PCF, 0);
        chk("rst_validd", ValidD, 0);
        chk("rst_rwe", RegWriteE, 0);
        chk("rst_rwm", RegWriteM, 0);
        chk("rst_rww", RegWriteW, 0);
        chk("rst_retire", RetireCount, 0);
        chk("rst_bubble", BubbleCount, 0);
        reset = 1'b1;

        // PC stepping after release.
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("pc_step", PCF, 64'(4 * i));
        end

        // Straight-line flow of one write slot.
        RA1D = 3; RA2D = 5; WA3D = 7; RegWriteD = 1;
        step();
        chk("sl_ra1e", RA1E, 3);
        chk("sl_ra2e", RA2E, 5);
        clear_inputs();
        step();
        chk("sl_wa3m", WA3M, 7);
        chk("sl_rwm", RegWriteM, 1);
        step();
        chk("sl_wa3w", WA3W, 7);
        chk("sl_rww", RegWriteW, 1);
        repeat (2) step();
        chk("pc_before_branch", PCF, 32'h20);

        // Branch redirect with StallF also raised.
        BranchTakenE = 1; BranchTargetE = 32'h100; StallF = 1; FlushD = 1; FlushE = 1;
        step();
        chk("br_pcf", PCF, 32'h100);
        chk("br_validd", ValidD, 0);
        chk("br_wa3e", WA3E, 0);
        chk("br_ra1e", RA1E, 0);
        chk("br_rwe", RegWriteE, 0);
        clear_inputs();

        // PC wrap modulo 2^32.
        BranchTakenE = 1; BranchTargetE = 32'hFFFF_FFFC;
        step();
        clear_inputs();
        step();
        chk("pc_wrap", PCF, 0);

        // Load-use: load in D, then stall F/D and bubble E.
        step();
        MemtoRegD = 1; RegWriteD = 1; WA3D = 2;
        step();
        StallF = 1; StallD = 1; FlushE = 1;
        step();
        chk("lu_rwe", RegWriteE, 0);
        chk("lu_m2re", MemtoRegE, 0);
        clear_inputs();
        repeat (4) step();

        // Flush beats stall in D.
        StallD = 1; FlushD = 1;
        step();
        chk("fd_validd", ValidD, 0);
        chk("fd_instrd", InstrD, 0);
        clear_inputs();

        // Async reset between edges with a write in M.
        step();
        WA3D = 9; RegWriteD = 1;
        step();
        clear_inputs();
        step();
        @(negedge clk);
        #1;
        chk("pre_rst_wa3m", WA3M, 9);
        chk("pre_rst_rwm", RegWriteM, 1);
        reset = 1'b0;
        #1;
        chk("async_rwm", RegWriteM, 0);
        chk("async_wa3m", WA3M, 0);
        chk("async_pcf", PCF, 0);
        chk("async_validd", ValidD, 0);
        chk("async_retire", RetireCount, 0);
        model_reset();
        repeat (2) step();
        reset = 1'b1;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            step();
        end
        clear_inputs();
        repeat (4) step();

        @(negedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_pipe_tracker.md
Name: hazard_pipe_tracker

Overview:
- Stage-register and control tracker for the vector CPU pipeline.
- Carries register-address and write-control fields from Decode through Execute, Memory and Writeback.
- Applies the StallF/StallD/FlushD/FlushE commands issued by the hazard unit.
- Drives the RA*E/WA3*/RegWrite*/MemtoRegE fields the hazard unit consumes for forwarding and load-use detection.
- Also owns the fetch PC register, the F->D instruction register, and retire/bubble performance counters.

Parameters:
- AW, 8, register-address width (RA/WA fields).
- XLEN, 32, PC and instruction width.
- PC_STEP, 4, PC increment per fetch.
- CW, 32, performance-counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- InstrF  in  XLEN  instruction fetched at PCF.
- RA1D  in  AW  decoded source 1 address, aligned with InstrD.
- RA2D  in  AW  decoded source 2 address.
- WA3D  in  AW  decoded destination address.
- RegWriteD  in  1  decoded register-write enable.
- MemtoRegD  in  1  decoded load select.
- StallF  in  1  hold PCF.
- StallD  in  1  hold the D register.
- FlushD  in  1  clear the D register.
- FlushE  in  1  clear the E register.
- BranchTakenE  in  1  redirect fetch.
- BranchTargetE  in  XLEN  redirect address.
- PCF  out  XLEN  fetch PC.
- InstrD  out  XLEN  decode-stage instruction.
- ValidD  out  1  D stage holds a real instruction.
- RA1E  out  AW  E-stage source 1.
- RA2E  out  AW  E-stage source 2.
- WA3E  out  AW  E-stage destination.
- RegWriteE  out  1  E-stage write enable.
- MemtoRegE  out  1  E-stage load flag.
- WA3M  out  AW  M-stage destination.
- RegWriteM  out  1  M-stage write enable.
- MemtoRegM  out  1  M-stage load flag.
- WA3W  out  AW  W-stage destination.
- RegWriteW  out  1  W-stage write enable.
- MemtoRegW  out  1  W-stage load flag.
- RetireCount  out  CW  instructions retired.
- BubbleCount  out  CW  bubble cycles at W.

Behaviour:
- Reset (reset=0, asynchronous):
  - PCF=0, InstrD=0, ValidD=0.
  - All E/M/W addresses=0, all RegWrite*/MemtoReg*=0, all internal valid bits=0.
  - Both counters=0.
  - State holds until the first rising clk after reset returns to 1.
- Fetch PC, priority order:
  - BranchTakenE: PCF<=BranchTargetE; StallF is ignored.
  - else StallF=1: PCF holds.
  - else: PCF<=PCF+PC_STEP, wrapping modulo 2^XLEN.
- D register, priority order:
  - FlushD: InstrD<=0, ValidD<=0; flush beats stall.
  - else StallD: hold InstrD and ValidD.
  - else: InstrD<=InstrF, ValidD<=1.
- E register (no stall input):
  - FlushE: insert a bubble. All E fields=0, ValidE=0; RegWriteE and MemtoRegE must be 0.
  - else: capture the D fields; ValidE<=ValidD.
  - RegWriteE<=RegWriteD&ValidD and MemtoRegE<=MemtoRegD&ValidD, so an invalid D slot never produces a write.
- M and W registers:
  - Advance unconditionally every cycle: E->M, M->W, including the valid bit.
- Latency:
  - A field presented at D with no stall/flush appears at E after 1 edge, M after 2, W after 3.
  - During a StallD hold, the D-side inputs are resampled each cycle. D fields are combinational from InstrD, so they are stable during the hold.
- Counters:
  - RetireCount increments when ValidW=1.
  - BubbleCount increments when ValidW=0 and the pipe has filled, i.e. at least 4 edges since reset.
  - Both wrap modulo 2^CW.
- All outputs are registered; no combinational input-to-output path.
- Simultaneous events:
  - StallF&StallD&FlushE (load-use): PCF and D hold, E gets a bubble, M/W advance.
  - BranchTakenE&FlushD&FlushE: PCF takes the target, D and E are cleared in the same edge.
- Reset mid-operation clears every stage immediately, with no completion of in-flight entries.

Test Plan:
- Reset held low 3 cycles with InstrF=0xDEADBEEF → PCF=0, ValidD=0, all RegWrite*=0, counters=0; after release, PCF steps 0,4,8,12 on successive edges.
- Straight-line flow: RA1D=3, RA2D=5, WA3D=7, RegWriteD=1 for one cycle, then zeros → RA1E=3/RA2E=5 after edge 1, WA3M=7 with RegWriteM=1 after edge 2, WA3W=7 with RegWriteW=1 after edge 3; RetireCount increments once for that slot.
- Load-use stall: MemtoRegD=1, WA3D=2, then StallF=StallD=FlushE=1 for one cycle → PCF and InstrD unchanged, RegWriteE=0 and MemtoRegE=0 for the bubble, BubbleCount +1 three edges later.
- Branch redirect: PCF=0x20, BranchTakenE=1, BranchTargetE=0x100, StallF=1, FlushD=FlushE=1 → next PCF=0x100, ValidD=0, E fields all 0.
- FlushD with StallD both 1 → ValidD=0, InstrD=0 (flush wins).
- Async reset asserted mid-cycle with RegWriteM=1, WA3M=9 → RegWriteM=0 and WA3M=0 immediately, without waiting for a clk edge.
